lemming_world: RTL



---
 rtl/lemming_world_if.sv | 26 ++
 rtl/lemming_world.sv | 111 +++++++++++
 2 files changed

// File: rtl/lemming_world_if.sv
// Handshake bundle between the Lemmings3 walker FSM (master) and the terrain model (slave).
interface lemming_world_if;
    logic       walk_left;
    logic       walk_right;
    logic       aaah;
    logic       digging;
    logic       ground;
    logic       bump_left;
    logic       bump_right;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [4:0] fall_cnt;
    logic       splat;

    // FSM side: drives intent, observes the world
    modport master (
        output walk_left, walk_right, aaah, digging,
        input  ground, bump_left, bump_right, pos_x, pos_y, fall_cnt, splat
    );

    // World side: consumes intent, publishes terrain feedback and position
    modport slave (
        input  walk_left, walk_right, aaah, digging,
        output ground, bump_left, bump_right, pos_x, pos_y, fall_cnt, splat
    );
endinterface

// File: rtl/lemming_world.sv
// Column-height terrain and single-lemming position model closing the walker FSM loop.
// All feedback outputs are decoded from registered state only, so the loop has no
// combinational cycle and the FSM sees the effect of its own output one edge later.
module lemming_world #(
    parameter int unsigned      W         = 16,
    parameter int unsigned      H         = 8,
    parameter int unsigned      X0        = 4,
    parameter logic [4*W-1:0]   INIT_SURF = {W{4'd4}},
    parameter int unsigned      FALL_MAX  = 20
) (
    input  logic              clk,
    input  logic              rst,
    lemming_world_if.slave    bus
);

    localparam int unsigned XW      = 4;
    localparam int unsigned YW      = 4;
    localparam int unsigned CW      = 5;
    localparam logic [XW-1:0] X_MAX  = XW'(W - 1);
    localparam logic [YW-1:0] H_ROW  = YW'(H);
    localparam logic [XW-1:0] X_RST  = XW'(X0);
    localparam logic [YW-1:0] Y_RST  = INIT_SURF[4*X0 +: 4] - 4'd1;
    localparam logic [CW-1:0] C_SAT  = CW'(31);

    logic [3:0]    surf_q [W];
    logic [3:0]    surf_d [W];
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] fall_q, fall_d;
    logic          splat_q, splat_d;

    logic [XW-1:0] xl_c, xr_c;
    logic [3:0]    surf_cur_c;
    logic          ground_c, bump_left_c, bump_right_c, fall_over_c;

    // Terrain feedback decoded from the current column and its neighbours
    always_comb begin
        xl_c         = x_q - 4'd1;
        xr_c         = x_q + 4'd1;
        surf_cur_c   = surf_q[x_q];
        ground_c     = (surf_cur_c == (y_q + 4'd1));
        bump_left_c  = (x_q == '0)    || (surf_q[xl_c] <= y_q);
        bump_right_c = (x_q == X_MAX) || (surf_q[xr_c] <= y_q);
        fall_over_c  = (32'(fall_q) > 32'(FALL_MAX));
    end

    // Next state: one action per cycle, splat > aaah > dig > walk
    always_comb begin
        surf_d  = surf_q;
        x_d     = x_q;
        y_d     = y_q;
        fall_d  = fall_q;
        splat_d = splat_q;
        if (splat_q) begin
            // dead lemming: everything frozen until reset
        end else if (bus.aaah) begin
            if (!ground_c) begin
                y_d = y_q + 4'd1;
            end
            if (fall_q != C_SAT) begin
                fall_d = fall_q + 5'd1;
            end
            if (ground_c && fall_over_c) begin
                splat_d = 1'b1;
            end
        end else begin
            fall_d = '0;
            if (bus.digging) begin
                // bedrock row H never gives way
                if (surf_cur_c < H_ROW) begin
                    surf_d[x_q] = surf_cur_c + 4'd1;
                end
            end else if (bus.walk_left && bus.walk_right) begin
                // contradictory request: stay put
            end else if (bus.walk_left && !bump_left_c) begin
                x_d = x_q - 4'd1;
            end else if (bus.walk_right && !bump_right_c) begin
                x_d = x_q + 4'd1;
            end
        end
    end

    // State registers, async reset puts the lemming on the initial ground at X0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(W); c++) begin
                surf_q[c] <= INIT_SURF[4*c +: 4];
            end
            x_q     <= X_RST;
            y_q     <= Y_RST;
            fall_q  <= '0;
            splat_q <= 1'b0;
        end else begin
            surf_q  <= surf_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fall_q  <= fall_d;
            splat_q <= splat_d;
        end
    end

    // Publish state and decoded feedback onto the bus
    assign bus.ground     = ground_c;
    assign bus.bump_left  = bump_left_c;
    assign bus.bump_right = bump_right_c;
    assign bus.pos_x      = x_q;
    assign bus.pos_y      = y_q;
    assign bus.fall_cnt   = fall_q;
    assign bus.splat      = splat_q;

endmodule
